stage_if: RTL and testbench

STAGE_IF -- requirements
Module: stage_if

---
 rtl/stage_if.sv | 113 +++++++++++
 tb/tb_stage_if.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// Instruction-fetch stage: one outstanding request, PC-tagged response buffer, redirect handling.
// Define BR32_IF_FETCH_BUF_EN for a two-entry buffer that keeps fetching while decode holds its head.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXN_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exn,
  input  logic        id_stall,
  input  logic        id_branch,
  input  logic [31:0] id_branch_dest,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_nextpc,
  output logic [31:0] if_instr,
  output logic        if_bubble,
  output logic        if_stall
);

`ifdef BR32_IF_FETCH_BUF_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   pend_pc;
  logic [31:0]   dpc;
  entry_t        fifo_q [2];
  logic [CW-1:0] count;

  logic          redirect;
  logic [31:0]   target;
  logic          busy;
  logic [CW:0]   used;
  logic          hs;
  logic          push;
  logic          pop;
  logic [CW-1:0] keep;

  // Exception outranks a branch; a branch is only honoured when decode is not holding.
  assign redirect = exn | (id_branch & ~id_stall);
  assign target   = exn ? EXN_VEC : {id_branch_dest[31:2], 2'b00};
  assign busy     = (state != IDLE);
  assign used     = (CW+1)'(count) + (CW+1)'(busy);

  // Request only with a free slot counting the owed response; never during reset or a redirect.
  assign imem_req  = rst_n & ~redirect
                   & ((state == IDLE) | ((state == WAIT) & imem_rvalid))
                   & (used < (CW+1)'(DEPTH));
  assign imem_addr = fpc;
  assign hs        = imem_req & imem_gnt;

  assign push = (state == WAIT) & imem_rvalid & ~redirect;
  assign pop  = ~id_stall & (count != '0) & ~redirect;
  assign keep = count - CW'(pop);

  assign if_bubble = (count == '0);
  assign if_pc     = if_bubble ? dpc : fifo_q[0].pc;
  assign if_nextpc = if_pc + 32'd4;
  assign if_instr  = if_bubble ? 32'd0 : fifo_q[0].instr;
  assign if_stall  = if_bubble & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      pend_pc   <= RESET_PC;
      dpc       <= RESET_PC;
      count     <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (redirect) begin
      // A response still owed after the flush belongs to the old path and is dropped on arrival.
      fpc   <= target;
      dpc   <= target;
      count <= '0;
      state <= (busy && !imem_rvalid) ? KILL : IDLE;
    end else begin
      if (hs) begin
        fpc     <= fpc + 32'd4;
        pend_pc <= fpc;
      end
      case (state)
        IDLE:    if (hs) state <= WAIT;
        WAIT:    if (imem_rvalid && !hs) state <= IDLE;
        KILL:    if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (pop) begin
        dpc       <= fifo_q[0].pc + 32'd4;
        fifo_q[0] <= fifo_q[1];
      end
      if (push) fifo_q[keep[0]] <= '{pc: pend_pc, instr: imem_rdata};
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if with a one-cycle-latency instruction memory model.
module tb_stage_if;

`ifdef BR32_IF_FETCH_BUF_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exn, id_stall, id_branch;
  logic [31:0] id_branch_dest;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_nextpc, if_instr;
  logic        if_bubble, if_stall;

  stage_if dut (
    .clk(clk), .rst_n(rst_n), .exn(exn), .id_stall(id_stall),
    .id_branch(id_branch), .id_branch_dest(id_branch_dest),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_nextpc(if_nextpc), .if_instr(if_instr),
    .if_bubble(if_bubble), .if_stall(if_stall)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic        mem_auto, hold_en, last_hs;
  logic [31:0] hold_addr, last_addr;
  logic [31:0] hs_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] instr_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: sample handshake/pop before the edge, then the memory answers the next cycle.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = imem_req && imem_gnt;
    a  = imem_addr;
    if (hs) hs_log.push_back(a);
    if (!if_bubble && !id_stall && !exn && !id_branch) begin
      pc_log.push_back(if_pc);
      instr_log.push_back(if_instr);
    end
    last_hs   = hs;
    last_addr = a;
    @(negedge clk);
    if (mem_auto) begin
      imem_rvalid = hs && !(hold_en && a == hold_addr);
      imem_rdata  = imem_rvalid ? 32'h1111_0001 + a : 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; exn = 1'b0; id_stall = 1'b0; id_branch = 1'b0; id_branch_dest = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_auto = 1'b1; hold_en = 1'b0; hold_addr = '0;
    tick();
    tick();
    hs_log.delete(); pc_log.delete(); instr_log.delete();
  endtask

  task automatic run_until_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (pc_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(pc_log.size() >= n), 32'd1);
  endtask

  initial begin
    int n;
    int k;
    logic [31:0] s_pc, s_instr;

    // Reset values
    rst_n = 1'b0; exn = 1'b0; id_stall = 1'b0; id_branch = 1'b0; id_branch_dest = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_auto = 1'b1; hold_en = 1'b0; hold_addr = '0; last_hs = 1'b0; last_addr = '0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_bubble", 32'(if_bubble), 32'd1);
    chk("rst_stall", 32'(if_stall), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    do_reset();

    // Streaming fetch after reset release
    rst_n = 1'b1; imem_gnt = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    chk("wait_bubble", 32'(if_bubble), 32'd1);
    chk("wait_stall", 32'(if_stall), 32'd1);
    tick();
    chk("head_pc", if_pc, 32'h0);
    chk("head_instr", if_instr, 32'h1111_0001);
    chk("head_bubble", 32'(if_bubble), 32'd0);
    chk("head_nextpc", if_nextpc, 32'h4);
    chk("head_stall", 32'(if_stall), 32'd0);
    run_until_pops(4, 40, "stream_timeout");
    for (int i = 0; i < 4; i++) begin
      chk("stream_addr", hs_log[i], 32'(4 * i));
      chk("stream_pc", pc_log[i], 32'(4 * i));
      chk("stream_instr", instr_log[i], 32'h1111_0001 + 32'(4 * i));
    end

    // Branch while the response for 0x8 is owed
    do_reset();
    rst_n = 1'b1; imem_gnt = 1'b1; hold_en = 1'b1; hold_addr = 32'h8;
    k = 0;
    do begin tick(); k++; end while (!(last_hs && last_addr == 32'h8) && k < 30);
    chk("br_wait8", 32'(last_hs && last_addr == 32'h8), 32'd1);
    pc_log.delete(); instr_log.delete();
    id_branch = 1'b1; id_branch_dest = 32'h0000_0203;
    #1;
    chk("br_noreq", 32'(imem_req), 32'd0);
    tick();
    id_branch = 1'b0;
    #1;
    chk("br_kill_req", 32'(imem_req), 32'd0);
    chk("br_bubble", 32'(if_bubble), 32'd1);
    chk("br_pc", if_pc, 32'h200);
    chk("br_addr", imem_addr, 32'h200);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0008;
    tick();
    chk("br_drop_bubble", 32'(if_bubble), 32'd1);
    chk("br_req_after", 32'(imem_req), 32'd1);
    hold_en = 1'b0;
    n = hs_log.size();
    run_until_pops(2, 20, "br_timeout");
    chk("br_hs_addr", hs_log[n], 32'h200);
    chk("br_pop_pc", pc_log[0], 32'h200);
    chk("br_pop_instr", instr_log[0], 32'h1111_0201);
    chk("br_pop_pc2", pc_log[1], 32'h204);

    // Exception and branch together: exception wins
    exn = 1'b1; id_branch = 1'b1; id_branch_dest = 32'h40;
    #1;
    chk("exn_noreq", 32'(imem_req), 32'd0);
    tick();
    exn = 1'b0; id_branch = 1'b0;
    #1;
    chk("exn_bubble", 32'(if_bubble), 32'd1);
    chk("exn_pc", if_pc, 32'h100);
    chk("exn_addr", imem_addr, 32'h100);
    pc_log.delete(); instr_log.delete();
    n = hs_log.size();
    run_until_pops(1, 20, "exn_timeout");
    chk("exn_hs_addr", hs_log[n], 32'h100);
    chk("exn_pop_pc", pc_log[0], 32'h100);
    chk("exn_pop_instr", instr_log[0], 32'h1111_0101);

    // Branch to the top word, PC wraps to zero; low dest bits ignored
    id_branch = 1'b1; id_branch_dest = 32'hFFFF_FFFF;
    tick();
    id_branch = 1'b0;
    pc_log.delete(); instr_log.delete();
    n = hs_log.size();
    run_until_pops(2, 30, "wrap_timeout");
    chk("wrap_hs0", hs_log[n], 32'hFFFF_FFFC);
    chk("wrap_hs1", hs_log[n+1], 32'h0);
    chk("wrap_pc0", pc_log[0], 32'hFFFF_FFFC);
    chk("wrap_instr0", instr_log[0], 32'h1110_FFFD);
    chk("wrap_pc1", pc_log[1], 32'h0);

    // Decode stall holds outputs; buffer fills, requests stop
    do_reset();
    rst_n = 1'b1; imem_gnt = 1'b1;
    k = 0;
    do begin tick(); k++; end while (if_bubble && k < 10);
    chk("stall_head", 32'(if_bubble), 32'd0);
    id_stall = 1'b1;
    s_pc = if_pc; s_instr = if_instr;
    n = hs_log.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", if_pc, s_pc);
      chk("stall_instr", if_instr, s_instr);
      chk("stall_bubble", 32'(if_bubble), 32'd0);
    end
    chk("stall_no_hs", 32'(hs_log.size() - n), 32'd0);
    chk("stall_req", 32'(imem_req), 32'd0);
    id_stall = 1'b0;
    tick();
    chk("unstall_pc", if_pc, 32'h4);
    chk("unstall_bubble", 32'(if_bubble), (DEPTH == 2) ? 32'd0 : 32'd1);
    run_until_pops(4, 40, "unstall_timeout");
    for (int i = 0; i < 4; i++) chk("unstall_order", pc_log[i], 32'(4 * i));

    // Reset while a response is owed; late response dropped; grant withheld
    do_reset();
    rst_n = 1'b1; imem_gnt = 1'b1; hold_en = 1'b1; hold_addr = 32'h0;
    tick();
    chk("mid_stall", 32'(if_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_stall", 32'(if_stall), 32'd0);
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_pc", if_pc, 32'h0);
    chk("async_bubble", 32'(if_bubble), 32'd1);
    tick();
    rst_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
    #1;
    chk("nogn_req", 32'(imem_req), 32'd1);
    chk("nogn_addr", imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nogn_req_hold", 32'(imem_req), 32'd1);
      chk("nogn_addr_hold", imem_addr, 32'h0);
      chk("nogn_bubble", 32'(if_bubble), 32'd1);
    end
    hold_en = 1'b0; imem_gnt = 1'b1;
    pc_log.delete(); instr_log.delete();
    run_until_pops(1, 10, "late_timeout");
    chk("late_pc", pc_log[0], 32'h0);
    chk("late_instr", instr_log[0], 32'h1111_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
